// File: rtl/vme_simple_master.sv
// Single-outstanding initiator for the VME-style register bus: valid/ready command in,
// one-cycle read/write strobe out, Done or timeout turned into a valid/ready response.
module vme_simple_master #(
   parameter int unsigned ADDR_WIDTH = 8,
   parameter int unsigned DATA_WIDTH = 32,
   parameter int unsigned TIMEOUT    = 255
) (
   input  logic                  Clk,
   input  logic                  rst_n,
   input  logic                  cmd_valid,
   output logic                  cmd_ready,
   input  logic                  cmd_write,
   input  logic [ADDR_WIDTH-1:0] cmd_addr,
   input  logic [DATA_WIDTH-1:0] cmd_wdata,
   output logic                  rsp_valid,
   input  logic                  rsp_ready,
   output logic [DATA_WIDTH-1:0] rsp_rdata,
   output logic                  rsp_error,
   output logic [ADDR_WIDTH-1:0] VMEAddr,
   output logic [DATA_WIDTH-1:0] VMEWrData,
   output logic                  VMERdMem,
   output logic                  VMEWrMem,
   input  logic [DATA_WIDTH-1:0] VMERdData,
   input  logic                  VMERdDone,
   input  logic                  VMEWrDone
);

   localparam int unsigned CntWidth = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
   localparam logic [CntWidth-1:0] CntMax = CntWidth'(TIMEOUT);

   typedef enum logic [1:0] {StIdle, StStrobe, StWait, StResp} state_e;

   state_e                  state_q, state_d;
   logic                    write_q, write_d;
   logic [ADDR_WIDTH-1:0]   addr_q, addr_d;
   logic [DATA_WIDTH-1:0]   wdata_q, wdata_d;
   logic                    rd_q, rd_d;
   logic                    wr_q, wr_d;
   logic                    rsp_valid_q, rsp_valid_d;
   logic [DATA_WIDTH-1:0]   rsp_rdata_q, rsp_rdata_d;
   logic                    rsp_error_q, rsp_error_d;
   logic [CntWidth-1:0]     cnt_q, cnt_d;
   logic                    done;

   // Only the Done of the current direction counts; the other one is ignored.
   assign done = write_q ? VMEWrDone : VMERdDone;

   always_comb begin
      state_d     = state_q;
      write_d     = write_q;
      addr_d      = addr_q;
      wdata_d     = wdata_q;
      rd_d        = 1'b0;
      wr_d        = 1'b0;
      rsp_valid_d = rsp_valid_q;
      rsp_rdata_d = rsp_rdata_q;
      rsp_error_d = rsp_error_q;
      cnt_d       = cnt_q;
      case (state_q)
         StIdle: begin
            if (cmd_valid) begin
               addr_d  = cmd_addr;
               write_d = cmd_write;
               if (cmd_write) begin
                  wdata_d = cmd_wdata;
               end
               wr_d    = cmd_write;
               rd_d    = !cmd_write;
               state_d = StStrobe;
            end
         end
         StStrobe: begin
            // Done is not looked at here so a stale ack from a timed-out access is dropped.
            cnt_d   = '0;
            state_d = StWait;
         end
         StWait: begin
            if (done) begin
               rsp_valid_d = 1'b1;
               rsp_rdata_d = write_q ? '0 : VMERdData;
               rsp_error_d = 1'b0;
               state_d     = StResp;
            end else if (TIMEOUT != 0) begin
               cnt_d = cnt_q + CntWidth'(1);
               if (cnt_d == CntMax) begin
                  rsp_valid_d = 1'b1;
                  rsp_rdata_d = '0;
                  rsp_error_d = 1'b1;
                  state_d     = StResp;
               end
            end
         end
         StResp: begin
            if (rsp_ready) begin
               rsp_valid_d = 1'b0;
               state_d     = StIdle;
            end
         end
         default: state_d = StIdle;
      endcase
   end

   always_ff @(posedge Clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q     <= StIdle;
         write_q     <= 1'b0;
         addr_q      <= '0;
         wdata_q     <= '0;
         rd_q        <= 1'b0;
         wr_q        <= 1'b0;
         rsp_valid_q <= 1'b0;
         rsp_rdata_q <= '0;
         rsp_error_q <= 1'b0;
         cnt_q       <= '0;
      end else begin
         state_q     <= state_d;
         write_q     <= write_d;
         addr_q      <= addr_d;
         wdata_q     <= wdata_d;
         rd_q        <= rd_d;
         wr_q        <= wr_d;
         rsp_valid_q <= rsp_valid_d;
         rsp_rdata_q <= rsp_rdata_d;
         rsp_error_q <= rsp_error_d;
         cnt_q       <= cnt_d;
      end
   end

   // Gated with rst_n so no command is offered while reset is held.
   assign cmd_ready = rst_n && (state_q == StIdle);
   assign rsp_valid = rsp_valid_q;
   assign rsp_rdata = rsp_rdata_q;
   assign rsp_error = rsp_error_q;
   assign VMEAddr   = addr_q;
   assign VMEWrData = wdata_q;
   assign VMERdMem  = rd_q;
   assign VMEWrMem  = wr_q;

endmodule
